fp_add_arbiter: RTL and testbench

//  Shares one fp_add instance between N requesters. Round-robin arbitration, at most one issue per cycle.

---
 rtl/fp_add_arbiter.sv | 109 ++++++++++
 tb/tb_fp_add_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin front end that shares one fp_add between N requesters.
// Carries the requester ID beside each operation in a tag pipe matched to the adder latency.
module fp_add_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_in1,
  input  logic [N*W-1:0]   req_in2,
  input  logic [N*3-1:0]   req_rm,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     add_in1,
  output logic [W-1:0]     add_in2,
  output logic [2:0]       add_rm,
  output logic             add_act,
  input  logic [W-1:0]     add_out,
  input  logic [3:0]       add_flags,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [W-1:0]     res_out,
  output logic [3:0]       res_flags,
  output logic             busy,
  output logic             idle
);

  localparam int unsigned TAGW = LAT * IDW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state;
  logic [IDW-1:0]             rr_ptr;
  logic [IDW-1:0]             issue_id;
  logic [LAT-1:0]             tag_v;
  logic [LAT-1:0][IDW-1:0]    tag_id;
  logic [IDW-1:0]             win_id;
  logic                       win_any;
  logic                       grant_ok;
  int unsigned                idx;

  // Rotating priority search starting just past the last winner.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(rr_ptr) + i) % N;
      if (!win_any && req[IDW'(idx)]) begin
        win_any = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // en low suppresses grants in the very cycle it falls.
  assign grant_ok = (state == RUN) && en;

  always_comb begin
    gnt = '0;
    if (grant_ok && win_any) gnt[win_id] = 1'b1;
  end

  assign busy      = add_act | (|tag_v);
  assign idle      = (state == IDLE);
  assign res_valid = tag_v[LAT-1];
  assign res_id    = tag_id[LAT-1];
  assign res_out   = res_valid ? add_out : '0;
  assign res_flags = res_valid ? add_flags : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(N - 1);
      add_in1  <= '0;
      add_in2  <= '0;
      add_rm   <= '0;
      add_act  <= 1'b0;
      issue_id <= '0;
      tag_v    <= '0;
      tag_id   <= '0;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN:   if (en) state <= RUN;
                 else if (!busy) state <= IDLE;
        default: state <= IDLE;
      endcase

      add_act <= |gnt;
      if (|gnt) begin
        rr_ptr   <= win_id;
        issue_id <= win_id;
        add_in1  <= req_in1[win_id*W +: W];
        add_in2  <= req_in2[win_id*W +: W];
        add_rm   <= req_rm[win_id*3 +: 3];
      end

      // Tag pipe shifts every clock so results line up with the adder output.
      tag_v  <= LAT'({tag_v, add_act});
      tag_id <= TAGW'({tag_id, issue_id});
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a small lookup-based fp_add model.
module tb_fp_add_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_in1;
  logic [N*W-1:0]   req_in2;
  logic [N*3-1:0]   req_rm;
  logic [N-1:0]     gnt;
  logic [W-1:0]     add_in1;
  logic [W-1:0]     add_in2;
  logic [2:0]       add_rm;
  logic             add_act;
  logic [W-1:0]     add_out;
  logic [3:0]       add_flags;
  logic             res_valid;
  logic [IDW-1:0]   res_id;
  logic [W-1:0]     res_out;
  logic [3:0]       res_flags;
  logic             busy;
  logic             idle;

  fp_add_arbiter #(.N(N), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .req_in1(req_in1), .req_in2(req_in2), .req_rm(req_rm), .gnt(gnt),
    .add_in1(add_in1), .add_in2(add_in2), .add_rm(add_rm), .add_act(add_act),
    .add_out(add_out), .add_flags(add_flags),
    .res_valid(res_valid), .res_id(res_id), .res_out(res_out), .res_flags(res_flags),
    .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  // fp_add stand-in: known sums only, LAT-cycle pipeline, flags {ov,un,inv,inexact}.
  function automatic logic [35:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return {4'b0000, 32'h40400000};
      64'h40000000_40000000: return {4'b0000, 32'h40800000};
      64'h3F800000_3F800000: return {4'b0000, 32'h40000000};
      64'h3F000000_3F000000: return {4'b0000, 32'h3F800000};
      64'h7F800000_FF800000: return {4'b0010, 32'h7FC00000};
      64'h7F7FFFFF_7F7FFFFF: return {4'b1001, 32'h7F800000};
      default:               return {4'b0000, 32'h0BAD0BAD};
    endcase
  endfunction

  logic [35:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= fp_model(add_in1, add_in2);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign add_out   = mp[LAT-1][31:0];
  assign add_flags = mp[LAT-1][35:32];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] out;
    logic [3:0]  flags;
  } exp_t;
  exp_t q[$];

  task automatic expect_res(input int id, input logic [31:0] o, input logic [3:0] f);
    exp_t e;
    e.due = cyc + 1 + LAT;
    e.id = id;
    e.out = o;
    e.flags = f;
    q.push_back(e);
  endtask

  // Result scoreboard: exact cycle, ID, value and flags; silence otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        chk("res_valid", res_valid, 1);
        chk("res_id", res_id, q[0].id);
        chk("res_out", res_out, q[0].out);
        chk("res_flags", res_flags, q[0].flags);
        void'(q.pop_front());
      end else begin
        chk("res_valid_quiet", res_valid, 0);
        chk("res_out_gated", res_out, 0);
        chk("res_flags_gated", res_flags, 0);
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;
  vec_t tv [6];

  logic [31:0] std_a [4] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000};
  logic [31:0] std_b [4] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000};
  logic [31:0] std_o [4] = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] eg;
    int bt;
    int fid;

    tv[0] = '{0, 32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 4'b0000};
    tv[1] = '{1, 32'h40000000, 32'h40000000, 3'd1, 32'h40800000, 4'b0000};
    tv[2] = '{2, 32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 4'b0010};
    tv[3] = '{1, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 32'h7F800000, 4'b1001};
    tv[4] = '{0, 32'h3F000000, 32'h3F000000, 3'd4, 32'h3F800000, 4'b0000};
    tv[5] = '{3, 32'h3F800000, 32'h3F800000, 3'd3, 32'h40000000, 4'b0000};

    rst = 1'b0; en = 1'b0; req = '0; req_in1 = '0; req_in2 = '0; req_rm = '0;
    @(negedge clk); #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_add_act", add_act, 0);
    chk("rst_add_in1", add_in1, 0);
    chk("rst_add_in2", add_in2, 0);
    chk("rst_add_rm", add_rm, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idle", idle, 1);

    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    #1 chk("run_idle", idle, 0);
    @(negedge clk);

    // Isolated operations through the table.
    for (int v = 0; v < 6; v++) begin
      req_in1[tv[v].id*W +: W] = tv[v].a;
      req_in2[tv[v].id*W +: W] = tv[v].b;
      req_rm[tv[v].id*3 +: 3]  = tv[v].rm;
      req = '0; req[tv[v].id] = 1'b1;
      eg  = '0; eg[tv[v].id]  = 1'b1;
      #1 chk("vec_gnt", gnt, eg);
      expect_res(tv[v].id, tv[v].exp_out, tv[v].exp_flags);
      @(negedge clk);
      req = '0;
      #1;
      chk("vec_add_act", add_act, 1);
      chk("vec_add_in1", add_in1, tv[v].a);
      chk("vec_add_in2", add_in2, tv[v].b);
      chk("vec_add_rm", add_rm, tv[v].rm);
      chk("vec_busy", busy, 1);
      repeat (3) @(negedge clk);
    end

    for (int k = 0; k < 4; k++) begin
      req_in1[k*W +: W] = std_a[k];
      req_in2[k*W +: W] = std_b[k];
      req_rm[k*3 +: 3]  = 3'(k);
    end

    // Contention: all four held, pointer at 3 -> 0,1,2,3 back to back.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      eg = '0; eg[k] = 1'b1;
      #1 chk("contend_gnt", gnt, eg);
      expect_res(k, std_o[k], 4'b0000);
      @(negedge clk);
    end
    req = '0;
    #1 chk("contend_no_req_gnt", gnt, 0);
    repeat (4) @(negedge clk);

    // Drain with three ops in flight.
    req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      eg = '0; eg[k] = 1'b1;
      #1 chk("drain_issue_gnt", gnt, eg);
      expect_res(k, std_o[k], 4'b0000);
      @(negedge clk);
    end
    en = 1'b0; req = 4'b1111;
    #1;
    chk("drain_gnt", gnt, 0);
    chk("drain_busy", busy, 1);
    bt = 0;
    while (busy && bt < 20) begin
      @(negedge clk); #1;
      bt++;
      chk("drain_gnt_hold", gnt, 0);
    end
    chk("drain_busy_fell", busy, 0);
    chk("drain_idle_before", idle, 0);
    @(negedge clk); #1;
    chk("drain_idle_after", idle, 1);
    req = '0;

    // Fairness: 1 and 2 alternate; first cycle after en is still IDLE.
    en = 1'b1; req = 4'b0110;
    #1;
    chk("enable_cycle_gnt", gnt, 0);
    chk("enable_cycle_idle", idle, 1);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      fid = (k % 2 == 0) ? 1 : 2;
      eg = '0; eg[fid] = 1'b1;
      #1 chk("fair_gnt", gnt, eg);
      expect_res(fid, std_o[fid], 4'b0000);
      @(negedge clk);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Reset with two ops in the pipe.
    req = 4'b1000;
    #1 chk("pre_reset_gnt3", gnt, 4'b1000);
    @(negedge clk);
    req = 4'b0100;
    #1 chk("pre_reset_gnt2", gnt, 4'b0100);
    @(negedge clk);
    req = 4'b1111;
    #1 chk("pre_reset_busy", busy, 1);
    #1 rst = 1'b0;
    q.delete();
    #1;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_add_act", add_act, 0);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_idle", idle, 1);
    @(negedge clk); #1;
    chk("reset_hold_gnt", gnt, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_gnt", gnt, 4'b0001);
    expect_res(0, std_o[0], 4'b0000);
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
